// File: rtl/store_buffer_if.sv
// Bus bundle for the store buffer: CPU-side load/store request and
// response signals plus the data_mem port it drives.
interface store_buffer_if #(
  parameter int CNT_W = 3
);
  logic [31:0]      cpu_adr;
  logic [31:0]      cpu_wdata;
  logic             cpu_mrd;
  logic             cpu_mwr;
  logic [31:0]      cpu_rdata;
  logic             stall;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [31:0]      mem_adr;
  logic [31:0]      mem_d_in;
  logic             mem_mrd;
  logic             mem_mwr;
  logic [31:0]      mem_d_out;

  // Environment side: the CPU datapath together with data_mem.
  modport master (
    output cpu_adr, cpu_wdata, cpu_mrd, cpu_mwr, mem_d_out,
    input  cpu_rdata, stall, empty, count,
           mem_adr, mem_d_in, mem_mrd, mem_mwr
  );

  // Store buffer side.
  modport slave (
    input  cpu_adr, cpu_wdata, cpu_mrd, cpu_mwr, mem_d_out,
    output cpu_rdata, stall, empty, count,
           mem_adr, mem_d_in, mem_mrd, mem_mwr
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer between the datapath and data_mem. Stores are queued in a
// small FIFO and drained in program order on cycles where no load needs the
// memory port. Loads go straight to memory, with the youngest buffered store
// to the same address forwarded in place of the memory data.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  store_buffer_if.slave bus
);

  logic [31:0]      adr_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic        full;
  logic        push;
  logic        pop;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  // A full buffer refuses the store even when a drain frees a slot in the
  // same cycle; the CPU simply retries on the next cycle.
  assign full = (count_q == CNT_W'(DEPTH));
  assign push = bus.cpu_mwr && !full;
  assign pop  = !bus.cpu_mrd && (count_q != '0);

  assign bus.stall = bus.cpu_mwr && full;
  assign bus.empty = (count_q == '0);
  assign bus.count = count_q;

  // Forwarding search from oldest to youngest so the youngest match wins.
  // The entry being pushed this cycle is not yet in the array, so a load
  // issued alongside a store never sees its own store.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[head_q + PTR_W'(i)] && (adr_q[head_q + PTR_W'(i)] == bus.cpu_adr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head_q + PTR_W'(i)];
      end
    end
  end

  // Load data: forwarded store data on a hit, memory data otherwise.
  assign bus.cpu_rdata = !bus.cpu_mrd ? 32'h0 :
                         fwd_hit      ? fwd_data : bus.mem_d_out;

  // Memory port select: loads take priority, otherwise drain the head entry.
  always_comb begin
    bus.mem_adr  = '0;
    bus.mem_d_in = '0;
    bus.mem_mrd  = 1'b0;
    bus.mem_mwr  = 1'b0;
    if (bus.cpu_mrd) begin
      bus.mem_mrd = 1'b1;
      bus.mem_adr = bus.cpu_adr;
    end else if (pop) begin
      bus.mem_mwr  = 1'b1;
      bus.mem_adr  = adr_q[head_q];
      bus.mem_d_in = data_q[head_q];
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  // NOTE: payload storage has no reset -- the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[tail_q]  <= bus.cpu_adr;
      data_q[tail_q] <= bus.cpu_wdata;
    end
  end

  // Control state: pointers wrap naturally at DEPTH, count tells full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small data_mem model behind it.
module tb_store_buffer;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  store_buffer_if #(.CNT_W(3)) bus ();

  store_buffer #(.DEPTH(4), .PTR_W(2), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_mem model: 1024 words, asynchronous read, write on posedge.
  logic [31:0] mem [1024];
  logic        mem_loaded = 1'b0;
  logic [31:0] wr_cnt     = 32'h0;

  function automatic logic [31:0] mem_init_val(input int idx);
    return (idx == 26) ? 32'h1 : (32'hF000_0000 | 32'(idx));
  endfunction

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= mem_init_val(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_mwr) begin
      mem[bus.mem_adr[11:2]] <= bus.mem_d_in;
      wr_cnt <= wr_cnt + 32'h1;
    end
  end

  assign bus.mem_d_out = mem[bus.mem_adr[11:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mrd, input logic mwr,
                       input logic [31:0] adr, input logic [31:0] wdata);
    bus.cpu_mrd   = mrd;
    bus.cpu_mwr   = mwr;
    bus.cpu_adr   = adr;
    bus.cpu_wdata = wdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] wr_snap;

  initial begin
    // Reset state, with a load held to show mem_mrd follows cpu_mrd.
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    check("rst_empty", 32'(bus.empty), 32'h1);
    check("rst_stall", 32'(bus.stall), 32'h0);
    check("rst_mwr",   32'(bus.mem_mwr), 32'h0);
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_mrd",   32'(bus.mem_mrd), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    // Single store drains the next cycle, then reads back from memory.
    tick();
    drive(1'b0, 1'b1, 32'h64, 32'hAA);
    check("s1_stall", 32'(bus.stall), 32'h0);
    check("s1_nowr",  32'(bus.mem_mwr), 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("s1_mwr",   32'(bus.mem_mwr), 32'h1);
    check("s1_adr",   bus.mem_adr, 32'h64);
    check("s1_din",   bus.mem_d_in, 32'hAA);
    check("s1_count", 32'(bus.count), 32'h1);
    tick();
    check("s1_empty", 32'(bus.empty), 32'h1);
    check("s1_mem",   mem[10'h19], 32'hAA);
    drive(1'b1, 1'b0, 32'h64, 32'h0);
    check("s1_load",  bus.cpu_rdata, 32'hAA);
    check("s1_lmrd",  32'(bus.mem_mrd), 32'h1);

    // Fill with the drain blocked by a held load, then overflow.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 32'h100 + 32'(4 * k), 32'h1000 + 32'(k));
      check("fill_nowr", 32'(bus.mem_mwr), 32'h0);
      tick();
    end
    check("fill_count", 32'(bus.count), 32'h4);
    drive(1'b1, 1'b1, 32'h110, 32'h1004);
    check("full_stall", 32'(bus.stall), 32'h1);
    check("full_nowr",  32'(bus.mem_mwr), 32'h0);
    tick();
    check("full_count", 32'(bus.count), 32'h4);
    drive(1'b0, 1'b1, 32'h110, 32'h1004);
    check("d1_stall", 32'(bus.stall), 32'h1);
    check("d1_adr",   bus.mem_adr, 32'h100);
    tick();
    check("d2_count", 32'(bus.count), 32'h3);
    check("d2_stall", 32'(bus.stall), 32'h0);
    check("d2_adr",   bus.mem_adr, 32'h104);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("d3_count", 32'(bus.count), 32'h3);
    check("d3_adr",   bus.mem_adr, 32'h108);
    tick();
    check("d4_adr",   bus.mem_adr, 32'h10C);
    tick();
    check("d5_adr",   bus.mem_adr, 32'h110);
    check("d5_din",   bus.mem_d_in, 32'h1004);
    check("d5_count", 32'(bus.count), 32'h1);
    tick();
    check("d6_empty", 32'(bus.empty), 32'h1);
    check("d6_mem0",  mem[10'h40], 32'h1000);
    check("d6_mem4",  mem[10'h44], 32'h1004);

    // Forwarding: youngest match wins, the same-cycle store is excluded.
    drive(1'b1, 1'b1, 32'hC8, 32'h11);
    check("fw_excl1", bus.cpu_rdata, 32'hF000_0032);
    tick();
    drive(1'b1, 1'b1, 32'hC8, 32'h22);
    check("fw_excl2", bus.cpu_rdata, 32'h11);
    tick();
    drive(1'b1, 1'b0, 32'hC8, 32'h0);
    check("fw_young", bus.cpu_rdata, 32'h22);
    check("fw_memold", mem[10'h32], 32'hF000_0032);
    drive(1'b1, 1'b0, 32'h70, 32'h0);
    check("fw_nohit", bus.cpu_rdata, 32'hF000_001C);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("rdata_zero", bus.cpu_rdata, 32'h0);
    check("fw_dr1",   bus.mem_d_in, 32'h11);
    tick();
    check("fw_dr2",   bus.mem_d_in, 32'h22);
    tick();
    check("fw_mem",   mem[10'h32], 32'h22);
    check("idle_adr", bus.mem_adr, 32'h0);
    check("idle_mwr", 32'(bus.mem_mwr), 32'h0);
    check("idle_mrd", 32'(bus.mem_mrd), 32'h0);

    // Load from an empty buffer.
    drive(1'b1, 1'b0, 32'h68, 32'h0);
    check("ld_data", bus.cpu_rdata, 32'h1);
    check("ld_mrd",  32'(bus.mem_mrd), 32'h1);
    check("ld_mwr",  32'(bus.mem_mwr), 32'h0);

    // Simultaneous push and pop at count=2.
    drive(1'b1, 1'b1, 32'h300, 32'hA);
    tick();
    drive(1'b1, 1'b1, 32'h304, 32'hB);
    tick();
    drive(1'b0, 1'b1, 32'h308, 32'hC);
    check("pp_count0", 32'(bus.count), 32'h2);
    check("pp_adr0",   bus.mem_adr, 32'h300);
    check("pp_stall",  32'(bus.stall), 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("pp_count1", 32'(bus.count), 32'h2);
    check("pp_adr1",   bus.mem_adr, 32'h304);
    tick();
    check("pp_adr2",   bus.mem_adr, 32'h308);
    tick();
    check("pp_empty",  32'(bus.empty), 32'h1);
    check("pp_memA",   mem[10'hC0], 32'hA);
    check("pp_memB",   mem[10'hC1], 32'hB);
    check("pp_memC",   mem[10'hC2], 32'hC);

    // Reset pulse with three stores still buffered.
    drive(1'b1, 1'b1, 32'h400, 32'h77);
    tick();
    drive(1'b1, 1'b1, 32'h404, 32'h78);
    tick();
    drive(1'b1, 1'b1, 32'h408, 32'h79);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("mr_count", 32'(bus.count), 32'h3);
    check("mr_mwr",   32'(bus.mem_mwr), 32'h1);
    wr_snap = wr_cnt;
    rst = 1'b0;
    #1;
    check("mr_empty",  32'(bus.empty), 32'h1);
    check("mr_count0", 32'(bus.count), 32'h0);
    check("mr_mwr0",   32'(bus.mem_mwr), 32'h0);
    tick();
    #2;
    rst = 1'b1;
    repeat (3) tick();
    check("mr_nowr", wr_cnt, wr_snap);
    check("mr_mem0", mem[10'h100], 32'hF000_0100);
    check("mr_mem1", mem[10'h101], 32'hF000_0101);
    check("mr_mem2", mem[10'h102], 32'hF000_0102);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write buffer between the processor datapath and data_mem. Sits directly upstream of data_mem and drives its adr/d_in/mrd/mwr port.
- Accepts word stores into a small FIFO and drains them to memory in program order, one per cycle, whenever the memory port is not needed by a load.
- Loads bypass the FIFO to memory. The youngest buffered store to the same address is forwarded.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- PTR_W, 2, pointer width, log2(DEPTH).
- CNT_W, 3, occupancy counter width, log2(DEPTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cpu_adr  input  32  load/store byte address, word aligned.
- cpu_wdata  input  32  store data.
- cpu_mrd  input  1  load request.
- cpu_mwr  input  1  store request.
- cpu_rdata  output  32  load data.
- stall  output  1  store not accepted this cycle; CPU holds request.
- empty  output  1  FIFO empty.
- count  output  CNT_W  current occupancy.
- mem_adr  output  32  to data_mem adr.
- mem_d_in  output  32  to data_mem d_in.
- mem_mrd  output  1  to data_mem mrd.
- mem_mwr  output  1  to data_mem mwr.
- mem_d_out  input  32  from data_mem d_out.

Behaviour:
- Storage: DEPTH entries of {adr[31:0], data[31:0], valid}, plus head, tail and count registers.
- Reset (rst=0, asynchronous): head=tail=0, count=0, all valid=0, contents discarded.
  - Resulting outputs: empty=1, stall=0, mem_mwr=0.
  - mem_mrd follows cpu_mrd.
  - Reset mid-drain discards every unwritten store; no mem_mwr is asserted afterward for those stores.
- Push: on a posedge with cpu_mwr=1 and count<DEPTH, write {cpu_adr, cpu_wdata} at tail, set valid, advance tail (modulo DEPTH).
- Full: stall = cpu_mwr & (count==DEPTH), combinational. When full, no push occurs, even if a pop happens the same cycle. The store is accepted on a later cycle.
- Drain (combinational port select):
  - Condition: cpu_mrd=0 and count>0.
  - Drives mem_mwr=1, mem_adr=entry[head].adr, mem_d_in=entry[head].data, mem_mrd=0.
  - At the posedge, data_mem writes, head advances (modulo DEPTH) and that entry's valid clears.
- Load:
  - cpu_mrd=1 drives mem_mrd=1, mem_adr=cpu_adr, mem_mwr=0. Drain is blocked that cycle.
  - cpu_rdata = data of the youngest valid entry whose adr equals cpu_adr (full 32-bit compare, youngest = closest to tail). If no entry matches, cpu_rdata = mem_d_out.
  - cpu_rdata is combinational, zero latency.
- Idle: cpu_mrd=0 and count=0 gives mem_mrd=0, mem_mwr=0, mem_adr=0, mem_d_in=0.
- cpu_rdata=0 whenever cpu_mrd=0.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Simultaneous cpu_mrd and cpu_mwr: legal. The push happens at the posedge. The forwarding search for the load excludes the store being pushed that cycle.
- Pointer wrap: head and tail wrap at DEPTH. count distinguishes full from empty.
- Ordering: memory sees stores strictly in acceptance order. Two stores to the same address both reach memory, and the last value wins.
- Latency: a store accepted at cycle N reaches memory no earlier than the posedge ending cycle N+1, and only after all older entries are written.

Test Plan:
- Reset, then store adr=0x64 data=0xAA with cpu_mrd=0 -> next cycle mem_mwr=1, mem_adr=0x64, mem_d_in=0xAA, count=1. The following cycle empty=1, and a load of 0x64 returns 0xAA from memory.
- Hold a load of 0x200 while storing to 0x100, 0x104, 0x108, 0x10C -> count=4, no mem_mwr.
  - 5th store 0x110 -> stall=1, count stays 4.
  - Drop cpu_mrd -> 4 drain cycles with mem_adr 0x100, 0x104, 0x108, 0x10C in order. The 0x110 store is accepted only after count<4.
- With the drain blocked, store 0xC8<-0x11 then 0xC8<-0x22, then load 0xC8 -> cpu_rdata=0x22 while mem[0xC8] still holds its old value. After draining, mem[0xC8]=0x22.
- Load 0x68 with the FIFO empty and mem holding 1 -> cpu_rdata=1, mem_mrd=1, mem_mwr=0.
- Load 0x70 while the FIFO holds 0xC8 only -> cpu_rdata = mem_d_out (no false hit).
- With 3 buffered stores, pulse rst low mid-cycle -> empty=1 and count=0 immediately. No further mem_mwr, and target memory words are unchanged.
- At count=2 with cpu_mrd=0, issue a store -> a pop and a push in the same cycle, count stays 2, FIFO order preserved.
